// File: rtl/layer_0_stream_ctrl_if.sv
// Purpose : bundles the pixel-in stream, featuremap bus and status of layer_0_stream_ctrl.
// Ports   : control (start, abort), pixel stream (pix_data/pix_valid/pix_ready),
//           featuremap bus (fm_data/fm_valid/fm_vout), status (col, row, busy, done, err).
// master = controller side, slave = host/featuremap side.
interface layer_0_stream_ctrl_if #(
  parameter int DATA_WIDTH = 96,
  parameter int CNT_W      = 32
);
  logic                  start;
  logic                  abort;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [DATA_WIDTH-1:0] fm_data;
  logic                  fm_valid;
  logic                  fm_vout;
  logic [CNT_W-1:0]      col;
  logic [CNT_W-1:0]      row;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  start, abort, pix_data, pix_valid, fm_vout,
    output pix_ready, fm_data, fm_valid, col, row, busy, done, err
  );

  modport slave (
    output start, abort, pix_data, pix_valid, fm_vout,
    input  pix_ready, fm_data, fm_valid, col, row, busy, done, err
  );
endinterface

// File: rtl/layer_0_stream_ctrl.sv
// Purpose : frame sequencer for the layer-0 3x3 conv featuremaps: forwards a raster pixel frame,
//           flushes the line buffers with zero pixels, counts returned valid_out pulses.
// Latency : accepted pixel appears on fm_data/fm_valid 1 cycle later; no stall path downstream.
// Backpr. : pix_ready is high only in LOAD; upstream holds pix_valid until ready.
// Ports   : i_clk, i_rst (async active-high), io_bus (master modport of layer_0_stream_ctrl_if).
module layer_0_stream_ctrl #(
  parameter int DATA_WIDTH = 96,
  parameter int IMG_SIZE   = 416,
  parameter int FLUSH_LEN  = IMG_SIZE + 1,
  parameter int OUT_COUNT  = (IMG_SIZE - 2) * (IMG_SIZE - 2),
  parameter int CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  layer_0_stream_ctrl_if.master io_bus
);

  localparam logic [CNT_W-1:0] LP_LAST_POS   = CNT_W'(IMG_SIZE - 1);
  localparam logic [CNT_W-1:0] LP_FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);
  localparam logic [CNT_W-1:0] LP_OUT_MAX    = CNT_W'(OUT_COUNT);
  localparam logic [CNT_W-1:0] LP_ONE        = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_fm_data;
  logic                  r_fm_valid;
  logic [CNT_W-1:0]      r_col;
  logic [CNT_W-1:0]      r_row;
  logic [CNT_W-1:0]      r_out_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic w_accept;
  logic w_active;
  logic w_out_full;

  assign w_accept   = io_bus.pix_valid && (r_state == S_LOAD);
  assign w_active   = (r_state == S_LOAD) || (r_state == S_FLUSH) || (r_state == S_DRAIN);
  assign w_out_full = (r_out_cnt == LP_OUT_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_fm_data   <= '0;
      r_fm_valid  <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_out_cnt   <= '0;
      r_flush_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // A valid_out when no frame is running, or beyond the expected count, is a protocol error.
      if (io_bus.fm_vout && (!w_active || w_out_full)) begin
        r_err <= 1'b1;
      end

      // Saturating output counter; may reach its target while still flushing.
      if (w_active && io_bus.fm_vout && !w_out_full) begin
        r_out_cnt <= r_out_cnt + LP_ONE;
      end

      r_done <= 1'b0;

      if (io_bus.abort) begin
        // Later assignments override the counter update above.
        r_state     <= S_IDLE;
        r_fm_valid  <= 1'b0;
        r_col       <= '0;
        r_row       <= '0;
        r_out_cnt   <= '0;
        r_flush_cnt <= '0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_fm_valid <= 1'b0;
            if (io_bus.start) begin
              r_col       <= '0;
              r_row       <= '0;
              r_out_cnt   <= '0;
              r_flush_cnt <= '0;
              r_busy      <= 1'b1;
              r_state     <= S_LOAD;
            end
          end

          S_LOAD: begin
            r_fm_valid <= w_accept;
            if (w_accept) begin
              r_fm_data <= io_bus.pix_data;
              if (r_col == LP_LAST_POS) begin
                r_col <= '0;
                if (r_row == LP_LAST_POS) begin
                  r_row   <= '0;
                  r_state <= S_FLUSH;
                end else begin
                  r_row <= r_row + LP_ONE;
                end
              end else begin
                r_col <= r_col + LP_ONE;
              end
            end
          end

          S_FLUSH: begin
            r_fm_data   <= '0;
            r_fm_valid  <= 1'b1;
            r_flush_cnt <= r_flush_cnt + LP_ONE;
            if (r_flush_cnt == LP_FLUSH_LAST) begin
              r_state <= S_DRAIN;
            end
          end

          S_DRAIN: begin
            r_fm_valid <= 1'b0;
            if (w_out_full) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end

          S_DONE: begin
            r_fm_valid <= 1'b0;
            r_state    <= S_IDLE;
          end

          default: begin
            r_fm_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign io_bus.pix_ready = (r_state == S_LOAD);
  assign io_bus.fm_data   = r_fm_data;
  assign io_bus.fm_valid  = r_fm_valid;
  assign io_bus.col       = r_col;
  assign io_bus.row       = r_row;
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.err       = r_err;

endmodule

// File: tb/tb_layer_0_stream_ctrl.sv
// Bench for layer_0_stream_ctrl with a 4x4 frame (5 flush pixels, 4 outputs per frame).
// Pixel tables drive the stream; a queue holds the expected featuremap bus words.
module tb_layer_0_stream_ctrl;
  localparam int DW   = 96;
  localparam int IMG  = 4;
  localparam int FLEN = IMG + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_0_stream_ctrl_if #(.DATA_WIDTH(DW), .CNT_W(32)) bus ();

  layer_0_stream_ctrl #(
    .DATA_WIDTH(DW),
    .IMG_SIZE  (IMG),
    .CNT_W     (32)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus.master)
  );

  typedef struct {
    logic          vld;
    logic [DW-1:0] dat;
    logic [31:0]   exp_col;
    logic [31:0]   exp_row;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] last_dat;
  int            n_chk = 0;
  int            n_pass = 0;
  int            done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Featuremap bus monitor: every fm_valid word must match the next queued word.
  always @(negedge clk) begin : mon
    logic [DW-1:0] e;
    if (!rst) begin
      if (bus.done) done_cnt++;
      if (bus.fm_valid) begin
        if (sb_q.size() == 0) begin
          chk("fm_valid_unexpected", 32'(bus.fm_valid), 0);
        end else begin
          e = sb_q.pop_front();
          chk_d("fm_data", bus.fm_data, e);
        end
      end
    end
  end

  // Vector for the k-th accepted pixel (k = 1..16); position is the next pixel to be accepted.
  function automatic vec_t mk(input logic vld, input int val, input int k);
    vec_t v;
    v.vld = vld;
    v.dat = {32'(val + 32'h200), 32'(val + 32'h100), 32'(val)};
    if (k == IMG * IMG) begin
      v.exp_col = 0;
      v.exp_row = 0;
    end else begin
      v.exp_col = 32'(k % IMG);
      v.exp_row = 32'(k / IMG);
    end
    return v;
  endfunction

  task automatic fill_b2b(input int base);
    vecs.delete();
    for (int k = 1; k <= IMG * IMG; k++) vecs.push_back(mk(1'b1, base + k, k));
  endtask

  task automatic fill_tog(input int base);
    vecs.delete();
    for (int k = 1; k <= IMG * IMG; k++) begin
      vecs.push_back(mk(1'b1, base + k, k));
      if (k < IMG * IMG) vecs.push_back(mk(1'b0, 32'hDEAD, k));
    end
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_ready", 32'(bus.pix_ready), 1);
    chk("start_col", bus.col, 0);
    chk("start_row", bus.row, 0);
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.pix_valid = vecs[i].vld;
      bus.pix_data  = vecs[i].dat;
      chk($sformatf("pix_ready[%0d]", i), 32'(bus.pix_ready), 1);
      if (vecs[i].vld) begin
        sb_q.push_back(vecs[i].dat);
        last_dat = vecs[i].dat;
        // Last pixel of the frame: the zero flush words follow it directly.
        if (vecs[i].exp_col == 0 && vecs[i].exp_row == 0)
          for (int f = 0; f < FLEN; f++) sb_q.push_back('0);
      end
      @(negedge clk);
      chk($sformatf("col[%0d]", i), bus.col, vecs[i].exp_col);
      chk($sformatf("row[%0d]", i), bus.row, vecs[i].exp_row);
      if (!vecs[i].vld) chk_d($sformatf("fm_hold[%0d]", i), bus.fm_data, last_dat);
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic finish_frame(input int n_vout, input logic exp_err);
    int t;
    repeat (FLEN + 1) @(negedge clk);
    chk("flush_consumed", 32'(sb_q.size()), 0);
    chk("drain_busy", 32'(bus.busy), 1);
    chk("drain_fm_valid", 32'(bus.fm_valid), 0);
    for (int k = 0; k < n_vout; k++) begin
      bus.fm_vout = 1'b1;
      @(negedge clk);
    end
    bus.fm_vout = 1'b0;
    t = 0;
    while (!bus.done && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 32'(bus.done), 1);
    chk("busy_at_done", 32'(bus.busy), 0);
    @(negedge clk);
    chk("done_single", 32'(bus.done), 0);
    chk("err_after_frame", 32'(bus.err), 32'(exp_err));
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_ready", 32'(bus.pix_ready), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pix_ready"}, 32'(bus.pix_ready), 0);
    chk_d({tag, "_fm_data"}, bus.fm_data, '0);
    chk({tag, "_fm_valid"}, 32'(bus.fm_valid), 0);
    chk({tag, "_col"}, bus.col, 0);
    chk({tag, "_row"}, bus.row, 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int d0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.fm_vout   = 1'b0;
    last_dat      = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: back-to-back frame
    fill_b2b(0);
    start_frame();
    apply_range(0, IMG * IMG - 1);
    finish_frame(4, 1'b0);

    // 2: pix_valid toggling, wrap after the 4th accept
    fill_tog(16'h1000);
    start_frame();
    apply_range(0, 2 * IMG * IMG - 2);
    finish_frame(4, 1'b0);

    // 3: abort after 7 pixels, then start+abort together in IDLE, then a clean frame
    fill_b2b(16'h2000);
    start_frame();
    apply_range(0, 6);
    bus.fm_vout = 1'b1;
    repeat (2) @(negedge clk);
    bus.fm_vout = 1'b0;
    d0 = done_cnt;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_ready", 32'(bus.pix_ready), 0);
    chk("abort_col", bus.col, 0);
    chk("abort_row", bus.row, 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_fm_valid", 32'(bus.fm_valid), 0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", 32'(bus.busy), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    chk("abort_err", 32'(bus.err), 0);
    fill_b2b(16'h3000);
    start_frame();
    apply_range(0, IMG * IMG - 1);
    finish_frame(4, 1'b0);

    // 4a: a fifth valid_out in DRAIN raises err
    fill_b2b(16'h4000);
    start_frame();
    apply_range(0, IMG * IMG - 1);
    finish_frame(5, 1'b1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("err_cleared_by_rst", 32'(bus.err), 0);

    // 4b: valid_out in IDLE raises err, which survives a good frame
    bus.fm_vout = 1'b1;
    @(negedge clk);
    bus.fm_vout = 1'b0;
    chk("err_idle_vout", 32'(bus.err), 1);
    fill_b2b(16'h5000);
    start_frame();
    apply_range(0, IMG * IMG - 1);
    finish_frame(4, 1'b1);

    // 5: start during LOAD is ignored; rst mid-FLUSH resets outputs immediately
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_b2b(16'h6000);
    start_frame();
    apply_range(0, 4);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("load_start_col", bus.col, 1);
    chk("load_start_row", bus.row, 1);
    chk("load_start_busy", 32'(bus.busy), 1);
    apply_range(5, IMG * IMG - 1);
    repeat (2) @(negedge clk);
    chk("flush_fm_valid", 32'(bus.fm_valid), 1);
    #2 rst = 1'b1;
    #1 check_reset_vals("flush_rst");
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
